// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: memory op codes, FSM states
// and small op-classification helpers.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    localparam logic RST_ENABLE = 1'b0;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational byte/half/word formatter: lane enables, replicated store data,
// extended load data and alignment check for one access.
module lsu_fmt
    import mem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  i_addr,
    input  mem_op_t     i_op,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [1:0]  w_lane;
    logic        w_halfHi;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane numbers count from bit 0; big-endian maps byte address k to lane 3-k.
    always_comb begin
        w_lane     = BIG_ENDIAN ? ~i_addr : i_addr;
        w_halfHi   = BIG_ENDIAN ? ~i_addr[1] : i_addr[1];
        w_byte     = i_rdata[{w_lane, 3'b000} +: 8];
        w_half     = i_rdata[{w_halfHi, 4'b0000} +: 16];
        o_sel      = 4'b0000;
        o_wdata    = 32'd0;
        o_rdata    = 32'd0;
        o_misalign = 1'b0;
        case (i_op)
            MEM_LB: begin
                o_sel   = 4'b0001 << w_lane;
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            MEM_LBU: begin
                o_sel   = 4'b0001 << w_lane;
                o_rdata = {24'd0, w_byte};
            end
            MEM_LH: begin
                o_sel      = w_halfHi ? 4'b1100 : 4'b0011;
                o_rdata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_addr[0];
            end
            MEM_LHU: begin
                o_sel      = w_halfHi ? 4'b1100 : 4'b0011;
                o_rdata    = {16'd0, w_half};
                o_misalign = i_addr[0];
            end
            MEM_LW: begin
                o_sel      = 4'b1111;
                o_rdata    = i_rdata;
                o_misalign = |i_addr;
            end
            MEM_SB: begin
                o_sel   = 4'b0001 << w_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_SH: begin
                o_sel      = w_halfHi ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr[0];
            end
            MEM_SW: begin
                o_sel      = 4'b1111;
                o_wdata    = i_wdata;
                o_misalign = |i_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage with integrated load/store unit: non-memory ops pass straight
// through, memory ops stall the pipe while a req/ack bus access is outstanding.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] alu_res_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] store_data_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [4:0]  waddr_o,
    output logic        reg_we_o,
    output logic [31:0] mem_data_o,
    output logic        hi_we_o,
    output logic        lo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    lsu_state_t    r_state;
    lsu_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_result;
    logic [31:0]   r_addr;
    logic [31:0]   r_sdata;
    mem_op_t       r_op;
    logic [4:0]    r_waddr;
    logic          r_regwe;
    logic          r_drop;
    logic          r_err;

    mem_op_t       w_op;
    mem_op_t       w_fOp;
    logic [1:0]    w_fAddr;
    logic [31:0]   w_fData;
    logic [3:0]    w_sel;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ldata;
    logic          w_misalign;
    logic          w_isMem;
    logic          w_start;
    logic          w_timeout;

    // Once the access is launched the formatter runs off the captured op, so
    // the bus stays stable even if a flush lets the upstream register move on.
    assign w_op      = mem_op_t'(mem_op_i);
    assign w_isMem   = is_load(w_op) || is_store(w_op);
    assign w_fOp     = (r_state == ST_IDLE) ? w_op : r_op;
    assign w_fAddr   = (r_state == ST_IDLE) ? alu_res_i[1:0] : r_addr[1:0];
    assign w_fData   = (r_state == ST_IDLE) ? store_data_i : r_sdata;
    assign w_start   = (r_state == ST_IDLE) && w_isMem && !w_misalign && !flush_i;
    assign w_timeout = (r_cnt == LAST);

    lsu_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
        .i_addr     (w_fAddr),
        .i_op       (w_fOp),
        .i_wdata    (w_fData),
        .i_rdata    (mem_rdata_i),
        .o_sel      (w_sel),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ldata),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) r_state <= ST_IDLE;
        else                   r_state <= w_next;
    end

    // A flushed access still completes on the bus but skips the DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_BUSY;
            ST_BUSY: if (mem_ack_i || w_timeout)
                         w_next = (r_drop || flush_i) ? ST_IDLE : ST_DONE;
            ST_DONE: if (flush_i || !stall_i) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_op     <= MEM_NONE;
            r_waddr  <= '0;
            r_regwe  <= 1'b0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_drop <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_start) begin
                        r_addr  <= alu_res_i;
                        r_sdata <= store_data_i;
                        r_op    <= w_op;
                        r_waddr <= waddr_i;
                        r_regwe <= reg_we_i && is_load(w_op);
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (flush_i) r_drop <= 1'b1;
                    if (mem_ack_i) begin
                        r_result <= is_load(r_op) ? w_ldata : 32'd0;
                    end else if (w_timeout) begin
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        waddr_o     = '0;
        reg_we_o    = 1'b0;
        mem_data_o  = '0;
        hi_we_o     = 1'b0;
        lo_we_o     = 1'b0;
        hi_o        = '0;
        lo_o        = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = '0;
        mem_wdata_o = '0;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        if (rst != RST_ENABLE) begin
            hi_we_o = hi_we_i && !flush_i;
            lo_we_o = lo_we_i && !flush_i;
            hi_o    = hi_i;
            lo_o    = lo_i;
            case (r_state)
                ST_IDLE: begin
                    waddr_o     = waddr_i;
                    mem_data_o  = alu_res_i;
                    reg_we_o    = reg_we_i && !flush_i && !w_isMem;
                    misalign_o  = w_isMem && w_misalign;
                    stall_req_o = w_start;
                end
                ST_BUSY: begin
                    waddr_o     = r_waddr;
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store(r_op);
                    mem_addr_o  = {r_addr[31:2], 2'b00};
                    mem_sel_o   = w_sel;
                    mem_wdata_o = w_wdata;
                    stall_req_o = 1'b1;
                    bus_err_o   = w_timeout && !mem_ack_i;
                end
                ST_DONE: begin
                    waddr_o    = r_waddr;
                    mem_data_o = r_result;
                    reg_we_o   = r_regwe && !r_err && !flush_i;
                end
                default: ;
            endcase
        end
    end

endmodule
